mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the instruction cache (I side) and the data cache (D side) on cache-miss block transfers.
- Sequences each transfer through a four-state FSM.
- Returns per-requester BUSYWAIT. The caches forward these BUSYWAIT outputs into the stall logic that freezes the IF/ID through MEM/WB pipeline registers.
- Round-robin tiebreak prevents either side from starving the other.

Parameters:
ADDR_WIDTH, 28, block address width (word address minus 4-bit block offset)
DATA_WIDTH, 128, block width in bits

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  synchronous, active-high reset
I_READ  in  1  I-cache block read request, held until I_BUSYWAIT low
I_ADDRESS  in  ADDR_WIDTH  I-cache block address
I_READDATA  out  DATA_WIDTH  block returned to I-cache
I_BUSYWAIT  out  1  I-side stall
D_READ  in  1  D-cache block read request
D_WRITE  in  1  D-cache block write-back request
D_ADDRESS  in  ADDR_WIDTH  D-cache block address
D_WRITEDATA  in  DATA_WIDTH  write-back block
D_READDATA  out  DATA_WIDTH  block returned to D-cache
D_BUSYWAIT  out  1  D-side stall
MEM_READ  out  1  memory read strobe
MEM_WRITE  out  1  memory write strobe
MEM_ADDRESS  out  ADDR_WIDTH  memory block address
MEM_WRITEDATA  out  DATA_WIDTH  memory write data
MEM_READDATA  in  DATA_WIDTH  memory read data, valid when MEM_BUSYWAIT low in WAIT
MEM_BUSYWAIT  in  1  memory busy

Behaviour:
- Clock and reset: one clock CLK. RESET is synchronous and active-high.
- Reset (at any posedge with RESET=1, including mid-transfer):
  - state=IDLE, OWNER=I, LAST=I, latched address/data=0, I_READDATA=D_READDATA=0.
  - MEM_READ=MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
  - An aborted transfer is not completed; the requester keeps its request and is re-arbitrated after RESET falls.
- States: IDLE, GRANT, WAIT, DONE.
- IDLE:
  - On a posedge where any request is present, latch OWNER, address, write data and op (read/write), then go to GRANT.
  - Selection: D only -> D; I only -> I; both -> the side not equal to LAST.
  - D_READ and D_WRITE both high is treated as a write.
- GRANT (exactly 1 cycle):
  - MEM_READ/MEM_WRITE driven from the latched op; MEM_ADDRESS/MEM_WRITEDATA from latched values.
  - Next state WAIT unconditionally. Memory must raise MEM_BUSYWAIT by this posedge.
- WAIT:
  - Strobes and address held stable.
  - Stay while MEM_BUSYWAIT=1.
  - On a posedge with MEM_BUSYWAIT=0:
    - for a read, capture MEM_READDATA into the owner's READDATA register;
    - set LAST=OWNER;
    - go to DONE.
- DONE (exactly 1 cycle):
  - Strobes 0.
  - Owner's BUSYWAIT is low for this cycle only.
  - Next state IDLE. The requester drops or changes its request during this cycle.
- Requester busywait (combinational):
  - I_BUSYWAIT = I_READ & ~(state==DONE & OWNER==I).
  - D_BUSYWAIT = (D_READ|D_WRITE) & ~(state==DONE & OWNER==D).
  - The non-owner stays stalled for the whole transfer.
- READDATA registers hold their value until the next completed read for that side. Writes do not modify D_READDATA.
- Latency: with the request sampled at posedge 0 and MEM_BUSYWAIT high for L WAIT posedges, DONE is entered at posedge 2+L. Back-to-back transfers are separated by exactly one IDLE cycle.
- Request withdrawn mid-transfer: the transfer still completes; BUSYWAIT for that side reads 0 because its request is 0.
- MEM strobes are never asserted in IDLE or DONE. The address never changes between GRANT and DONE.

Test Plan:
1. Reset: drive random inputs, RESET=1 for 2 posedges -> all MEM_* = 0, I/D_READDATA = 0, state IDLE; I_READ=1 then gives I_BUSYWAIT=1.
2. Single I read: I_READ=1, I_ADDRESS=28'h0000010, memory L=3 returning 128'hA5A5...A5 -> MEM_READ high from posedge 1 to posedge 5, MEM_ADDRESS=28'h10; I_BUSYWAIT low only in the cycle after posedge 5; I_READDATA=128'hA5...A5.
3. D write-back: D_WRITE=1, D_ADDRESS=28'h20, D_WRITEDATA=128'h1234 -> MEM_WRITE=1 with MEM_WRITEDATA=128'h1234 through WAIT; D_READDATA unchanged (0).
4. Simultaneous requests after reset: I_READ=D_READ=1 in the same cycle -> D served first (LAST=I), I_BUSYWAIT stays 1 throughout; I granted one IDLE cycle after D's DONE. Repeat both -> order alternates I, D.
5. Reset mid-WAIT: RESET=1 for one posedge while D_READ is in WAIT -> MEM_READ=0 next cycle, D_READDATA=0; D transfer restarts from GRANT after RESET=0 with a fresh L.
6. Illegal D_READ=D_WRITE=1 with L=0 -> treated as a write, MEM_READ never asserted, DONE at posedge 2.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single main-memory block port between the instruction cache and
// the data cache. Each cache-miss block transfer runs IDLE -> GRANT -> WAIT ->
// DONE. When both caches request in the same cycle, the side that was served
// last loses, so neither cache can starve the other.
// The per-side BUSYWAIT outputs feed the pipeline stall logic and are
// combinational, so the owner sees its stall release in the DONE cycle itself.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  I_READ,
    input  logic [ADDR_WIDTH-1:0] I_ADDRESS,
    output logic [DATA_WIDTH-1:0] I_READDATA,
    output logic                  I_BUSYWAIT,
    input  logic                  D_READ,
    input  logic                  D_WRITE,
    input  logic [ADDR_WIDTH-1:0] D_ADDRESS,
    input  logic [DATA_WIDTH-1:0] D_WRITEDATA,
    output logic [DATA_WIDTH-1:0] D_READDATA,
    output logic                  D_BUSYWAIT,
    output logic                  MEM_READ,
    output logic                  MEM_WRITE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
    output logic [DATA_WIDTH-1:0] MEM_WRITEDATA,
    input  logic [DATA_WIDTH-1:0] MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Owner / last-served encoding: 0 = I side, 1 = D side.
    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    state_t                state_r;
    state_t                state_s;
    logic                  owner_r;
    logic                  last_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [DATA_WIDTH-1:0] i_rdata_r;
    logic [DATA_WIDTH-1:0] d_rdata_r;
    logic                  mem_read_r;
    logic                  mem_write_r;

    logic                  i_req_s;
    logic                  d_req_s;
    logic                  any_req_s;
    logic                  sel_d_s;
    logic                  sel_write_s;
    logic                  grant_s;
    logic                  complete_s;
    logic                  done_s;

    // Request decode, round-robin owner selection and transfer event strobes
    always_comb begin
        i_req_s   = I_READ;
        d_req_s   = D_READ | D_WRITE;
        any_req_s = i_req_s | d_req_s;
        sel_d_s   = 1'b0;
        if (i_req_s && d_req_s) begin
            // Contention: the side that was not served last wins.
            sel_d_s = (last_r == SIDE_I);
        end else begin
            sel_d_s = d_req_s;
        end
        // D_READ together with D_WRITE is resolved as a write-back.
        sel_write_s = sel_d_s & D_WRITE;
        grant_s     = (state_r == ST_IDLE) && any_req_s;
        complete_s  = (state_r == ST_WAIT) && !MEM_BUSYWAIT;
        done_s      = (state_r == ST_DONE);
    end

    // Next-state logic for the transfer sequencer
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_s = ST_GRANT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: state_s = ST_WAIT;
            ST_WAIT: begin
                if (!MEM_BUSYWAIT) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Sequencer state register; reset abandons any transfer in flight
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latch owner, address, write data and memory strobes at grant; drop strobes on completion
    always_ff @(posedge CLK) begin
        if (RESET) begin
            owner_r     <= SIDE_I;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            wdata_r     <= {DATA_WIDTH{1'b0}};
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
        end else if (grant_s) begin
            owner_r     <= sel_d_s;
            addr_r      <= sel_d_s ? D_ADDRESS : I_ADDRESS;
            wdata_r     <= sel_d_s ? D_WRITEDATA : {DATA_WIDTH{1'b0}};
            mem_read_r  <= ~sel_write_s;
            mem_write_r <= sel_write_s;
        end else if (complete_s) begin
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
        end
    end

    // Record the served side and capture returned read data when memory finishes
    always_ff @(posedge CLK) begin
        if (RESET) begin
            last_r    <= SIDE_I;
            i_rdata_r <= {DATA_WIDTH{1'b0}};
            d_rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (complete_s) begin
            last_r <= owner_r;
            if (mem_read_r && (owner_r == SIDE_D)) begin
                d_rdata_r <= MEM_READDATA;
            end
            if (mem_read_r && (owner_r == SIDE_I)) begin
                i_rdata_r <= MEM_READDATA;
            end
        end
    end

    assign MEM_READ      = mem_read_r;
    assign MEM_WRITE     = mem_write_r;
    assign MEM_ADDRESS   = addr_r;
    assign MEM_WRITEDATA = wdata_r;
    assign I_READDATA    = i_rdata_r;
    assign D_READDATA    = d_rdata_r;

    // Stall each requester until the DONE cycle of its own transfer.
    assign I_BUSYWAIT = i_req_s & ~(done_s & (owner_r == SIDE_I));
    assign D_BUSYWAIT = d_req_s & ~(done_s & (owner_r == SIDE_D));

endmodule
